data_memory_mmio: RTL and testbench

Responder on the CPU data-memory port: services every load/store the single-cycle CPU issues on `data_memory_a/we/wd/rd`. It maps a word RAM plus a small memory-mapped I/O window containing a free-running cycle counter and a buffered debug output FIFO. The FIFO is drained by the testbench or a downstream sink through a valid/ready port. This block replaces the plain data memory in CPU benches that need program-visible time and printed results.

---
 rtl/data_memory_mmio_if.sv | 21 ++
 rtl/data_memory_mmio.sv | 131 +++++++++++++
 tb/tb_data_memory_mmio.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_mmio_if.sv
// CPU data-memory port plus the debug output stream, bundled for the MMIO data memory.
// The CPU (or bench) side uses the master view; the memory uses the slave view.
interface data_memory_mmio_if;
  logic [31:0] a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output a, we, wd, out_ready,
    input  rd, out_valid, out_data
  );

  modport slave (
    input  a, we, wd, out_ready,
    output rd, out_valid, out_data
  );
endinterface

// File: rtl/data_memory_mmio.sv
// Word RAM plus an MMIO window (cycle counter, debug output FIFO, status, scratch)
// answering the single-cycle CPU's data port with zero-latency loads.
module data_memory_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_mmio_if.slave bus
);

  localparam int unsigned     RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned     PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W     = PTR_W + 1;
  localparam logic [31:0]     RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_CYCLE   = 2'd0,
    REG_OUT     = 2'd1,
    REG_STATUS  = 2'd2,
    REG_SCRATCH = 2'd3
  } mmio_reg_e;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              ovf;
  logic [31:0]       cycle_cnt;
  logic [31:0]       scratch;

  logic              is_ram;
  logic              is_mmio;
  mmio_reg_e         reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_out;
  logic              wr_status;
  logic              wr_scratch;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [31:0]       status_word;
  logic [31:0]       rd_mux;

  assign is_ram  = bus.a < RAM_BYTES;
  assign is_mmio = bus.a[31:4] == MMIO_BASE[31:4];
  assign reg_sel = mmio_reg_e'(bus.a[3:2]);
  assign ram_idx = bus.a[RAM_AW+1:2];

  assign wr_out     = bus.we && is_mmio && (reg_sel == REG_OUT);
  assign wr_status  = bus.we && is_mmio && (reg_sel == REG_STATUS);
  assign wr_scratch = bus.we && is_mmio && (reg_sel == REG_SCRATCH);

  assign empty = fifo_count == '0;
  assign full  = fifo_count == FULL_CNT;
  assign pop   = !empty && bus.out_ready;
  // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = wr_out && (!full || pop);
  assign drop    = wr_out && full && !pop;

  assign status_word = {16'h0000, 8'(fifo_count), 5'b00000, ovf, full, empty};

  assign bus.out_valid = !empty;
  assign bus.out_data  = fifo_mem[rd_ptr];

  // RAM is deliberately outside the reset domain so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (bus.we && is_ram) begin
      ram[ram_idx] <= bus.wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      scratch    <= '0;
      ovf        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_scratch) begin
        scratch <= bus.wd;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (wr_status) begin
        ovf <= 1'b0;
      end
      if (push_ok) begin
        fifo_mem[wr_ptr] <= bus.wd;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (is_ram) begin
      rd_mux = ram[ram_idx];
    end else if (is_mmio) begin
      case (reg_sel)
        REG_CYCLE:   rd_mux = cycle_cnt;
        REG_OUT:     rd_mux = '0;
        REG_STATUS:  rd_mux = status_word;
        REG_SCRATCH: rd_mux = scratch;
        default:     rd_mux = '0;
      endcase
    end
  end

  assign bus.rd = rd_mux;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: directed vector table, hand sequences for FIFO and reset
// corners, then random traffic compared against a queue/array reference model.
module tb_data_memory_mmio;

  localparam int unsigned RAM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam logic [31:0] A_CYC = BASE;
  localparam logic [31:0] A_OUT = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_SCR = BASE + 32'd12;
  localparam logic [31:0] A_IDLE = 32'h0000_0200;

  logic clk;
  logic rst_n;
  data_memory_mmio_if bus();

  data_memory_mmio #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [31:0] m_ram [RAM_WORDS];
  logic [31:0] m_cyc;
  logic [31:0] m_scr;
  logic        m_ovf;
  logic [31:0] m_q [$];

  logic [31:0] last_rd;
  logic        last_valid;
  logic [31:0] last_data;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [20];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    logic [31:0] w;
    w = addr & ~32'h3;
    if (addr < RAM_WORDS * 4) return m_ram[addr[7:2]];
    if (w == A_CYC) return m_cyc;
    if (w == A_ST)
      return {16'h0, 8'(m_q.size()), 5'h0, m_ovf,
              1'(m_q.size() == FIFO_DEPTH), 1'(m_q.size() == 0)};
    if (w == A_SCR) return m_scr;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_cyc = 32'h0;
    m_scr = 32'h0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  // One CPU cycle: drive at the falling edge, check, clock, then advance the model.
  task automatic apply_stimulus(input logic [31:0] addr, input logic w_en,
                                input logic [31:0] data, input logic rdy);
    logic [31:0] exp_rd;
    logic [31:0] w;
    logic        popped;
    bus.a = addr;
    bus.we = w_en;
    bus.wd = data;
    bus.out_ready = rdy;
    #1;
    last_rd = bus.rd;
    last_valid = bus.out_valid;
    last_data = bus.out_data;
    exp_rd = model_rd(addr);
    if (!$isunknown(exp_rd)) check_output("rd", last_rd, exp_rd);
    check_output("out_valid", 32'(last_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check_output("out_data", last_data, m_q[0]);
    @(posedge clk);
    w = addr & ~32'h3;
    popped = (m_q.size() > 0) && rdy;
    if (popped) void'(m_q.pop_front());
    if (w_en) begin
      if (addr < RAM_WORDS * 4) m_ram[addr[7:2]] = data;
      else if (w == A_OUT) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(data);
        else m_ovf = 1'b1;
      end
      else if (w == A_ST) m_ovf = 1'b0;
      else if (w == A_SCR) m_scr = data;
    end
    m_cyc = m_cyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] addr;
    int          sel;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < int'(RAM_WORDS); i++) m_ram[i] = 'x;
    model_reset();
    bus.a = 32'h0;
    bus.we = 1'b0;
    bus.wd = 32'h0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    bus.a = A_CYC;  #1 check_output("rst_cycle", bus.rd, 32'h0);
    bus.a = A_ST;   #1 check_output("rst_status", bus.rd, 32'h1);
    bus.a = A_SCR;  #1 check_output("rst_scratch", bus.rd, 32'h0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("rst_out_data", bus.out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < int'(RAM_WORDS); i++)
      apply_stimulus(32'(i * 4), 1'b1, $urandom, 1'b0);

    // Counter counts edges since reset release
    do_reset();
    for (int i = 0; i < 10; i++) apply_stimulus(A_IDLE, 1'b0, 32'h0, 1'b0);
    apply_stimulus(A_CYC, 1'b0, 32'h0, 1'b0);
    check_output("cycle_after_10", last_rd, 32'd10);

    vecs[0]  = '{32'h10,   1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{32'h10,   1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{32'h12,   1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[3]  = '{32'h100,  1'b0, 32'h0,         1'b0, 1'b1, 32'h0,   1'b0, 32'h0};
    vecs[4]  = '{A_OUT,    1'b1, 32'd1,         1'b0, 1'b1, 32'h0,   1'b0, 32'h0};
    vecs[5]  = '{A_OUT,    1'b1, 32'd2,         1'b0, 1'b1, 32'h0,   1'b1, 32'd1};
    vecs[6]  = '{A_OUT,    1'b1, 32'd3,         1'b0, 1'b1, 32'h0,   1'b1, 32'd1};
    vecs[7]  = '{A_OUT,    1'b1, 32'd4,         1'b0, 1'b1, 32'h0,   1'b1, 32'd1};
    vecs[8]  = '{A_ST,     1'b0, 32'h0,         1'b0, 1'b1, 32'h402, 1'b1, 32'd1};
    vecs[9]  = '{A_OUT,    1'b1, 32'd5,         1'b0, 1'b1, 32'h0,   1'b1, 32'd1};
    vecs[10] = '{A_ST,     1'b0, 32'h0,         1'b0, 1'b1, 32'h406, 1'b1, 32'd1};
    vecs[11] = '{A_ST,     1'b1, 32'h0,         1'b0, 1'b1, 32'h406, 1'b1, 32'd1};
    vecs[12] = '{A_ST,     1'b0, 32'h0,         1'b0, 1'b1, 32'h402, 1'b1, 32'd1};
    vecs[13] = '{A_OUT,    1'b1, 32'd6,         1'b1, 1'b1, 32'h0,   1'b1, 32'd1};
    vecs[14] = '{A_ST,     1'b0, 32'h0,         1'b0, 1'b1, 32'h402, 1'b1, 32'd2};
    vecs[15] = '{A_SCR,    1'b1, 32'd9,         1'b1, 1'b1, 32'h0,   1'b1, 32'd2};
    vecs[16] = '{A_SCR,    1'b0, 32'h0,         1'b1, 1'b1, 32'd9,   1'b1, 32'd3};
    vecs[17] = '{32'h200,  1'b0, 32'h0,         1'b1, 1'b1, 32'h0,   1'b1, 32'd4};
    vecs[18] = '{32'h4,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'd6};
    vecs[19] = '{A_ST,     1'b0, 32'h0,         1'b1, 1'b1, 32'h001, 1'b0, 32'h0};

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].rdy);
      if (vecs[i].chk_rd) check_output($sformatf("vec%0d_rd", i), last_rd, vecs[i].exp_rd);
      check_output($sformatf("vec%0d_valid", i), 32'(last_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check_output($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
    end

    // Push into an empty FIFO while the sink is already ready
    apply_stimulus(A_OUT, 1'b1, 32'd7, 1'b1);
    check_output("empty_push_valid0", 32'(last_valid), 32'h0);
    apply_stimulus(A_IDLE, 1'b0, 32'h0, 1'b1);
    check_output("empty_push_valid1", 32'(last_valid), 32'h1);
    check_output("empty_push_data", last_data, 32'd7);
    apply_stimulus(A_IDLE, 1'b0, 32'h0, 1'b1);
    check_output("empty_push_drained", 32'(last_valid), 32'h0);

    // Fill, then drain on consecutive edges in order
    for (int i = 0; i < 4; i++) apply_stimulus(A_OUT, 1'b1, 32'(11 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(A_IDLE, 1'b0, 32'h0, 1'b1);
      check_output($sformatf("drain%0d", i), last_data, 32'(11 + i));
    end
    apply_stimulus(A_IDLE, 1'b0, 32'h0, 1'b1);
    check_output("drain_empty", 32'(last_valid), 32'h0);

    // Counter wrap from all-ones
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFF;
    apply_stimulus(A_CYC, 1'b0, 32'h0, 1'b0);
    check_output("cycle_max", last_rd, 32'hFFFF_FFFF);
    apply_stimulus(A_CYC, 1'b0, 32'h0, 1'b0);
    check_output("cycle_wrap", last_rd, 32'h0);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2: addr = 32'($urandom_range(0, 255));
        3:       addr = A_CYC + 32'($urandom_range(0, 3));
        4:       addr = A_OUT + 32'($urandom_range(0, 3));
        5:       addr = A_ST + 32'($urandom_range(0, 3));
        6:       addr = A_SCR + 32'($urandom_range(0, 3));
        default: addr = ($urandom_range(0, 1) == 1) ? BASE + 32'($urandom_range(16, 255)) : $urandom;
      endcase
      apply_stimulus(addr, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Mid-run reset: MMIO state clears at once, RAM survives
    do_reset();
    apply_stimulus(32'h10, 1'b1, 32'h1234_5678, 1'b0);
    apply_stimulus(A_OUT, 1'b1, 32'hA1, 1'b0);
    apply_stimulus(A_OUT, 1'b1, 32'hA2, 1'b0);
    apply_stimulus(A_SCR, 1'b1, 32'd9, 1'b0);
    while (m_cyc != 32'd50) apply_stimulus(A_IDLE, 1'b0, 32'h0, 1'b0);
    apply_stimulus(A_CYC, 1'b0, 32'h0, 1'b0);
    check_output("cycle_50", last_rd, 32'd50);
    check_output("pre_reset_valid", 32'(bus.out_valid), 32'h1);
    bus.a = A_SCR;
    #1 check_output("pre_reset_scratch", bus.rd, 32'd9);
    rst_n = 1'b0;
    #1 check_output("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check_output("mid_rst_data", bus.out_data, 32'h0);
    bus.a = A_CYC;  #1 check_output("mid_rst_cycle", bus.rd, 32'h0);
    bus.a = A_SCR;  #1 check_output("mid_rst_scratch", bus.rd, 32'h0);
    bus.a = 32'h10; #1 check_output("mid_rst_ram", bus.rd, 32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply_stimulus(A_ST, 1'b0, 32'h0, 1'b0);
    apply_stimulus(A_CYC, 1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
